// File: rtl/synth_stim_harness.sv
// synth_stim_harness: narrow-pin stimulus expander plus MISR response compactor
// for isolated synthesis/timing runs of wide CGRA top levels. A narrow pin bus
// (or an internal LFSR) drives a wide registered DUT stimulus. All DUT outputs
// are folded into a MISR signature. The signature can be snapshotted and
// shifted out serially, MSB first, on a single pin.
// Optional build macro: SYNTH_HARNESS_CYCLE_CNT_EN appends a 16-bit count of
// enabled cycles to the dumped signature.
module synth_stim_harness #(
    parameter int             IN_W      = 100,
    parameter int             DUT_IN_W  = 256,
    parameter int             DUT_OUT_W = 512,
    parameter int             SIG_W     = 32,
    parameter logic [SIG_W-1:0] POLY    = 32'h0040_0007,
    parameter logic [SIG_W-1:0] SEED    = 32'h0000_0001
) (
    input  logic                 CLK_I,
    input  logic                 RST_N_I,
    input  logic                 EN_I,
    input  logic                 MODE_I,
    input  logic [IN_W-1:0]      IN_I,
    output logic [DUT_IN_W-1:0]  DUT_IN_O,
    input  logic [DUT_OUT_W-1:0] DUT_OUT_I,
    input  logic                 DUMP_I,
    output logic                 OUT_O,
    output logic                 DUMP_VALID_O,
    output logic [SIG_W-1:0]     SIG_O
);

`ifdef SYNTH_HARNESS_CYCLE_CNT_EN
    localparam int CNT_W = 16;
`else
    localparam int CNT_W = 0;
`endif
    localparam int DUMP_LEN = SIG_W + CNT_W;
    localparam int CW       = $clog2(DUMP_LEN);
    localparam int NSLICE   = (DUT_OUT_W + SIG_W - 1) / SIG_W;

    typedef enum logic {IDLE = 1'b0, DUMP = 1'b1} state_t;

    // One Galois shift shared by the LFSR and the MISR.
    function automatic logic [SIG_W-1:0] galois_step(input logic [SIG_W-1:0] v);
        return {v[SIG_W-2:0], 1'b0} ^ (v[SIG_W-1] ? POLY : '0);
    endfunction

    // XOR of all SIG_W-wide slices. The top slice is zero-padded.
    function automatic logic [SIG_W-1:0] fold_slices(input logic [DUT_OUT_W-1:0] v);
        logic [NSLICE*SIG_W-1:0] pad;
        logic [SIG_W-1:0]        acc;
        pad = '0;
        pad[DUT_OUT_W-1:0] = v;
        acc = '0;
        for (int i = 0; i < NSLICE; i++) begin
            acc ^= pad[i*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    logic [DUT_IN_W-1:0]  stim_q;
    logic [SIG_W-1:0]     lfsr_q;
    logic [SIG_W-1:0]     sig_q;
    logic [DUT_OUT_W-1:0] out_p0;
    logic [DUMP_LEN-1:0]  shadow_q;
    logic [CW-1:0]        cnt_q;
    logic                 out_bit_q;
    logic                 dvld_q;
    state_t               state_q;

    logic [DUT_IN_W-1:0]  shift_next;
    logic [DUT_IN_W-1:0]  rep_next;
    logic [SIG_W-1:0]     lfsr_next;
    logic [DUMP_LEN-1:0]  snap;

    generate
        if (IN_W >= DUT_IN_W) begin : g_wide_pins
            assign shift_next = IN_I[DUT_IN_W-1:0];
        end else begin : g_narrow_pins
            assign shift_next = {stim_q[DUT_IN_W-IN_W-1:0], IN_I};
        end
    endgenerate

    // Next LFSR state and its replication across the stimulus width.
    always_comb begin
        lfsr_next = galois_step(lfsr_q);
        rep_next  = '0;
        for (int i = 0; i < DUT_IN_W; i++) begin
            rep_next[i] = lfsr_next[i % SIG_W];
        end
    end

`ifdef SYNTH_HARNESS_CYCLE_CNT_EN
    logic [15:0] cyc_q;

    // Count enabled cycles, wrapping at 0xFFFF.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) cyc_q <= '0;
        else if (EN_I) cyc_q <= cyc_q + 16'd1;
    end

    assign snap = {sig_q, cyc_q};
`else
    assign snap = sig_q;
`endif

    // Stimulus source: pin shift or LFSR. Both hold while EN_I is low.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            stim_q <= '0;
            lfsr_q <= SEED;
        end else if (EN_I) begin
            if (MODE_I) begin
                lfsr_q <= lfsr_next;
                stim_q <= rep_next;
            end else begin
                stim_q <= shift_next;
            end
        end
    end

    // Response path: register the DUT outputs every cycle, then compact them into the MISR.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            out_p0 <= '0;
            sig_q  <= '0;
        end else begin
            out_p0 <= DUT_OUT_I;
            if (EN_I) sig_q <= galois_step(sig_q) ^ fold_slices(out_p0);
        end
    end

    // Dump FSM: snapshot on request, then shift the shadow out MSB first.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            cnt_q     <= '0;
            out_bit_q <= 1'b0;
            dvld_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (DUMP_I) begin
                        out_bit_q <= snap[DUMP_LEN-1];
                        shadow_q  <= snap << 1;
                        cnt_q     <= CW'(DUMP_LEN - 1);
                        dvld_q    <= 1'b1;
                        state_q   <= DUMP;
                    end
                end
                DUMP: begin
                    if (cnt_q == '0) begin
                        out_bit_q <= 1'b0;
                        dvld_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        out_bit_q <= shadow_q[DUMP_LEN-1];
                        shadow_q  <= shadow_q << 1;
                        cnt_q     <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DUT_IN_O     = stim_q;
    assign SIG_O        = sig_q;
    assign OUT_O        = out_bit_q;
    assign DUMP_VALID_O = dvld_q;

endmodule

// File: tb/tb_synth_stim_harness.sv
// Bench for synth_stim_harness: directed steps plus randomized traffic. The
// results are compared against a polynomial-arithmetic reference model.
module tb_synth_stim_harness;
    localparam int IN_W      = 8;
    localparam int DUT_IN_W  = 48;
    localparam int DUT_OUT_W = 64;
    localparam int SIG_W     = 32;
    localparam logic [31:0] POLY = 32'h0040_0007;
`ifdef SYNTH_HARNESS_CYCLE_CNT_EN
    localparam int DUMP_LEN = 48;
`else
    localparam int DUMP_LEN = 32;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [7:0]  in_pins;
    logic [47:0] dut_in;
    logic [63:0] dut_out;
    logic        dump;
    logic        out_bit;
    logic        dvld;
    logic [31:0] sig;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [47:0] m_stim;
    logic [31:0] m_lfsr;
    logic [31:0] m_sig;
    logic [63:0] m_outq;
    logic [15:0] m_cyc;
    bit          m_busy;
    bit          m_q[$];
    logic        m_out;
    logic        m_vld;

    logic [63:0] got;
    int          vcount;

    synth_stim_harness #(
        .IN_W(IN_W), .DUT_IN_W(DUT_IN_W), .DUT_OUT_W(DUT_OUT_W), .SIG_W(SIG_W),
        .POLY(POLY), .SEED(32'h0000_0001)
    ) dut (
        .CLK_I(clk), .RST_N_I(rst_n), .EN_I(en), .MODE_I(mode), .IN_I(in_pins),
        .DUT_IN_O(dut_in), .DUT_OUT_I(dut_out), .DUMP_I(dump), .OUT_O(out_bit),
        .DUMP_VALID_O(dvld), .SIG_O(sig)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // multiply by x modulo x^32 + POLY
    function automatic logic [31:0] mul_x(input logic [31:0] a);
        logic [32:0] t;
        t = {a, 1'b0};
        if (t[32]) t = t ^ {1'b1, POLY};
        return t[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stim = '0; m_lfsr = 32'h1; m_sig = '0; m_outq = '0; m_cyc = '0;
        m_busy = 0; m_q.delete(); m_out = 1'b0; m_vld = 1'b0;
    endtask

    // what one rising edge does, given the inputs present at that edge
    task automatic model_edge();
        logic [31:0] f;
        f = m_outq[63:32] ^ m_outq[31:0];
        if (m_busy) begin
            if (m_q.size() > 0) begin
                m_out = m_q.pop_front(); m_vld = 1'b1;
            end else begin
                m_busy = 0; m_out = 1'b0; m_vld = 1'b0;
            end
        end else if (dump) begin
            for (int k = 31; k >= 0; k--) m_q.push_back(m_sig[k]);
`ifdef SYNTH_HARNESS_CYCLE_CNT_EN
            for (int k = 15; k >= 0; k--) m_q.push_back(m_cyc[k]);
`endif
            m_out = m_q.pop_front(); m_vld = 1'b1; m_busy = 1;
        end
        if (en) begin
            if (mode) begin
                m_lfsr = mul_x(m_lfsr);
                m_stim = {m_lfsr[15:0], m_lfsr};
            end else begin
                m_stim = 48'((m_stim << 8) | 48'(in_pins));
            end
            m_sig = mul_x(m_sig) ^ f;
            m_cyc = m_cyc + 16'd1;
        end
        m_outq = dut_out;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic step_chk(input string tag);
        step();
        check({tag, "_stim"}, dut_in, m_stim);
        check({tag, "_sig"}, sig, m_sig);
        check({tag, "_vld"}, dvld, m_vld);
        check({tag, "_out"}, out_bit, m_out);
    endtask

    task automatic collect();
        if (dvld) begin
            got = {got[62:0], out_bit};
            vcount++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_stim", dut_in, 48'h0);
        check("rst_sig", sig, 32'h0);
        check("rst_out", out_bit, 1'b0);
        check("rst_vld", dvld, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_pins = '0; dut_out = '0; dump = 1'b0;
        model_reset();
        #12;
        check("por_stim", dut_in, 48'h0);
        check("por_sig", sig, 32'h0);
        check("por_out", out_bit, 1'b0);
        check("por_vld", dvld, 1'b0);
        rst_n = 1'b1;

        // pin shift
        en = 1'b1; mode = 1'b0; in_pins = 8'hA5;
        step_chk("shift1");
        check("shift1_const", dut_in, 48'h00A5);
        in_pins = 8'h3C;
        step_chk("shift2");
        check("shift2_const", dut_in, 48'hA53C);
        en = 1'b0; in_pins = 8'hFF;
        step_chk("shift_hold");
        check("shift_hold_const", dut_in, 48'hA53C);

        // LFSR stimulus
        do_reset();
        en = 1'b1; mode = 1'b1;
        step_chk("lfsr1");
        check("lfsr1_const", dut_in, 48'h0002_0000_0002);
        step_chk("lfsr2");
        check("lfsr2_const", dut_in, 48'h0004_0000_0004);
        step_chk("lfsr3");
        check("lfsr3_const", dut_in, 48'h0008_0000_0008);
        for (int i = 0; i < 28; i++) step_chk("lfsr_run");
        check("lfsr_msb_const", dut_in, 48'h0000_8000_0000);
        step_chk("lfsr_wrap");
        check("lfsr_wrap_const", dut_in, 48'h0007_0040_0007);

        // MISR latency
        do_reset();
        en = 1'b1; mode = 1'b0; dut_out = 64'h0000_0001_0000_0000;
        step_chk("misr_sample");
        dut_out = '0;
        step_chk("misr_a");
        check("misr_a_const", sig, 32'h1);
        step_chk("misr_b");
        check("misr_b_const", sig, 32'h2);

        // dump of 0x8000_0001 with an ignored mid-dump request, MISR running
        do_reset();
        en = 1'b1; dut_out = 64'h0000_0000_8000_0001;
        step_chk("dump_prep1");
        dut_out = '0;
        step_chk("dump_prep2");
        en = 1'b0;
        step_chk("dump_prep3");
        check("dump_sig_const", sig, 32'h8000_0001);
        got = '0; vcount = 0;
        dump = 1'b1;
        step_chk("dump_go");
        collect();
        dump = 1'b0; en = 1'b1;
        for (int i = 0; i < DUMP_LEN + 4; i++) begin
            dump = (i == 10);
            dut_out = {$urandom, $urandom};
            step_chk("dump_run");
            collect();
        end
        dump = 1'b0;
        check("dump_len", vcount, DUMP_LEN);
        check("dump_sig_bits", got[DUMP_LEN-1 -: 32], 32'h8000_0001);
`ifdef SYNTH_HARNESS_CYCLE_CNT_EN
        check("dump_cyc_bits", got[15:0], 16'h0002);
`endif

        // held request re-triggers after one idle cycle
        dump = 1'b1;
        for (int i = 0; i < 2 * DUMP_LEN + 4; i++) step_chk("dump_held");
        dump = 1'b0;

        // reset aborts a dump in progress
        dump = 1'b1;
        step_chk("abort_go");
        dump = 1'b0;
        for (int i = 0; i < 5; i++) step_chk("abort_run");
        do_reset();
        step_chk("abort_after");

`ifdef SYNTH_HARNESS_CYCLE_CNT_EN
        // cycle counter appended after the signature
        do_reset();
        en = 1'b1; dut_out = '0;
        for (int i = 0; i < 5; i++) step_chk("cnt_en");
        en = 1'b0; dump = 1'b1;
        got = '0; vcount = 0;
        step_chk("cnt_go");
        collect();
        dump = 1'b0;
        for (int i = 0; i < DUMP_LEN + 2; i++) begin
            step_chk("cnt_run");
            collect();
        end
        check("cnt_len", vcount, 48);
        check("cnt_bits", got[15:0], 16'h0005);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            mode    = $urandom_range(0, 1) == 1;
            in_pins = 8'($urandom);
            dut_out = {$urandom, $urandom};
            dump    = ($urandom_range(0, 15) == 0);
            if (i == 200) do_reset();
            step_chk("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
